switch_event_arbiter: RTL and testbench

Detects level changes on the debounced switch vector from the debounce stage. It latches each change as a pending event and serves the events one at a time to a single consumer. Service is round-robin over a valid/ready handshake. The block sits between the switch debounce stage and the control logic, and shares that consumer fairly among all switches. It records coalesced (lost) toggles in a sticky overrun vector.

---
 rtl/switch_event_arbiter.sv | 145 ++++++++++++++
 tb/tb_switch_event_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter
//
// Watches the debounced switch vector for level changes, latches each change as
// a pending event and hands the events one at a time to a single consumer over
// a valid/ready handshake. Pending switches are served round-robin, starting
// after the most recently granted index. A change that lands on a switch which
// already has an unserved event is coalesced and flagged in a sticky overrun bit.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   sw_in        debounced switch levels
//   sw_mask      per-switch enable; a 0 drops changes and any pending event
//   evt_valid    an event is presented (registered)
//   evt_ready    consumer accepts the presented event
//   evt_idx      index of the switch that changed (registered, stable while valid)
//   evt_level    level of that switch when it was granted
//   pending_any  OR of all pending bits (registered)
//   overrun      sticky per-switch coalesced-change flags
//   clr_overrun  write-1-to-clear strobe for overrun
//
// idx_width must satisfy 2**idx_width >= no_of_switches.

module switch_event_arbiter #(
    parameter int unsigned no_of_switches = 9,
    parameter int unsigned idx_width      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [no_of_switches-1:0] sw_in,
    input  logic [no_of_switches-1:0] sw_mask,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [idx_width-1:0]      evt_idx,
    output logic                      evt_level,
    output logic                      pending_any,
    output logic [no_of_switches-1:0] overrun,
    input  logic [no_of_switches-1:0] clr_overrun
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e                    state_q;
    logic [no_of_switches-1:0] prev_q;
    logic [no_of_switches-1:0] pending_q, pending_d;
    logic [no_of_switches-1:0] overrun_d;
    logic [idx_width-1:0]      last_q;

    logic [no_of_switches-1:0] change;
    logic [no_of_switches-1:0] upper_mask;
    logic [no_of_switches-1:0] upper_pending;
    logic [no_of_switches-1:0] grant_vec;
    logic                      grant_en;
    logic [idx_width-1:0]      grant_idx;
    logic                      grant_level;

    assign change = (sw_in ^ prev_q) & sw_mask;

    // Round-robin pick: lowest pending index above last_q wins; if there is none,
    // wrap and take the lowest pending index overall.
    always_comb begin
        upper_mask  = '0;
        grant_idx   = '0;
        grant_level = 1'b0;
        for (int i = 0; i < no_of_switches; i++) begin
            upper_mask[i] = (i > int'(last_q));
        end
        upper_pending = pending_q & upper_mask;
        for (int i = no_of_switches - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx   = idx_width'(i);
                grant_level = sw_in[i];
            end
        end
        for (int i = no_of_switches - 1; i >= 0; i--) begin
            if (upper_pending[i]) begin
                grant_idx   = idx_width'(i);
                grant_level = sw_in[i];
            end
        end
    end

    assign grant_en = (state_q == StIdle) && (|pending_q);

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < no_of_switches; i++) begin
            grant_vec[i] = grant_en && (grant_idx == idx_width'(i));
        end
    end

    // A change in the grant cycle re-arms the bit; a masked switch never holds
    // a pending event. Overrun set has priority over the clear strobe.
    always_comb begin
        pending_d = ((pending_q & ~grant_vec) | change) & sw_mask;
        overrun_d = (overrun & ~clr_overrun) | (change & pending_q & ~grant_vec);
    end

    always_ff @(posedge clock) begin
        // prev follows sw_in even in reset so release produces no spurious events.
        prev_q <= sw_in;
        if (reset) begin
            pending_q   <= '0;
            overrun     <= '0;
            pending_any <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            overrun     <= overrun_d;
            pending_any <= |pending_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_level <= 1'b0;
            last_q    <= idx_width'(no_of_switches - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_en) begin
                        state_q   <= StPresent;
                        evt_valid <= 1'b1;
                        evt_idx   <= grant_idx;
                        evt_level <= grant_level;
                        last_q    <= grant_idx;
                    end
                end
                StPresent: begin
                    if (evt_ready) begin
                        state_q   <= StIdle;
                        evt_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Self-checking bench for switch_event_arbiter: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.

module tb_switch_event_arbiter;

    localparam int N = 9;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] sw_in;
    logic [N-1:0] sw_mask;
    logic         evt_valid;
    logic         evt_ready;
    logic [3:0]   evt_idx;
    logic         evt_level;
    logic         pending_any;
    logic [N-1:0] overrun;
    logic [N-1:0] clr_overrun;

    switch_event_arbiter #(
        .no_of_switches(N),
        .idx_width     (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_in      (sw_in),
        .sw_mask    (sw_mask),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_idx    (evt_idx),
        .evt_level  (evt_level),
        .pending_any(pending_any),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit [N-1:0] m_prev  = '0;
    bit [N-1:0] m_pend  = '0;
    bit [N-1:0] m_ovr   = '0;
    int         m_last  = N - 1;
    bit         m_valid = 1'b0;
    int         m_idx   = 0;
    bit         m_level = 1'b0;

    // Handshakes observed on the DUT: idx + 16*level.
    int served[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int served_at(input int k);
        if (k < served.size()) return served[k];
        return -1;
    endfunction

    task automatic tick();
        bit [N-1:0] chg;
        bit [N-1:0] np;
        bit [N-1:0] no;
        int         g;
        if (evt_valid === 1'b1 && evt_ready === 1'b1)
            served.push_back(int'(evt_idx) + (evt_level ? 16 : 0));
        @(posedge clock);
        if (reset) begin
            m_pend  = '0;
            m_ovr   = '0;
            m_last  = N - 1;
            m_valid = 1'b0;
            m_idx   = 0;
            m_level = 1'b0;
        end else begin
            chg = (sw_in ^ m_prev) & sw_mask;
            g = -1;
            if (!m_valid) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                no[i] = (m_ovr[i] && !clr_overrun[i]) || (chg[i] && m_pend[i] && i != g);
                np[i] = sw_mask[i] && (chg[i] || (m_pend[i] && i != g));
            end
            m_pend = np;
            m_ovr  = no;
            if (m_valid) begin
                if (evt_ready) m_valid = 1'b0;
            end else if (g >= 0) begin
                m_valid = 1'b1;
                m_idx   = g;
                m_level = sw_in[g];
                m_last  = g;
            end
        end
        m_prev = sw_in;
        #1;
        check("valid", evt_valid, m_valid);
        check("idx", evt_idx, m_idx);
        check("level", evt_level, m_level);
        check("pending_any", pending_any, |m_pend);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic flip(input int b);
        sw_in[b] = ~sw_in[b];
    endtask

    initial begin
        int seen;
        reset       = 1'b1;
        sw_in       = 9'h0A5;
        sw_mask     = '1;
        evt_ready   = 1'b0;
        clr_overrun = '0;
        #2;

        // Reset baseline
        run(2);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid !== 1'b0) seen++;
        end
        check("base_no_valid", seen, 0);
        check("base_overrun", overrun, 0);

        // Single event, two-edge latency, then a bubble
        evt_ready = 1'b1;
        flip(3);
        tick();
        check("single_e0", evt_valid, 0);
        tick();
        check("single_e1", evt_valid, 1);
        check("single_idx", evt_idx, 3);
        check("single_lvl", evt_level, 1);
        tick();
        check("single_bubble", evt_valid, 0);
        run(3);

        // Round-robin from reset (last = 8), then again after last = 8
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        served.delete();
        flip(0); flip(4); flip(8);
        run(10);
        check("rr_n", served.size(), 3);
        check("rr_0", served_at(0) % 16, 0);
        check("rr_1", served_at(1) % 16, 4);
        check("rr_2", served_at(2) % 16, 8);
        served.delete();
        flip(0); flip(8);
        run(8);
        check("rr2_n", served.size(), 2);
        check("rr2_0", served_at(0) % 16, 0);
        check("rr2_1", served_at(1) % 16, 8);

        // Backpressure and overrun
        if (sw_in[2]) begin
            flip(2);
            run(6);
        end
        served.delete();
        evt_ready = 1'b0;
        flip(6);
        run(3);
        flip(2);
        tick();
        flip(2);
        tick();
        check("ovr_set", overrun[2], 1);
        evt_ready = 1'b1;
        run(8);
        check("bp_n", served.size(), 2);
        check("bp_first", served_at(0) % 16, 6);
        check("bp_second", served_at(1), 2);
        clr_overrun = 9'h004;
        tick();
        clr_overrun = '0;
        check("ovr_clr", overrun[2], 0);
        evt_ready = 1'b0;
        flip(6);
        run(3);
        flip(2);
        tick();
        flip(2);
        clr_overrun = 9'h004;
        tick();
        clr_overrun = '0;
        check("ovr_set_wins", overrun[2], 1);
        clr_overrun = 9'h004;
        tick();
        clr_overrun = '0;
        evt_ready = 1'b1;
        run(8);

        // Mask
        served.delete();
        sw_mask[5] = 1'b0;
        flip(5);
        run(6);
        check("mask_no_evt", served.size(), 0);
        sw_mask[5] = 1'b1;
        evt_ready = 1'b0;
        flip(6);
        run(3);
        flip(5);
        tick();
        check("mask_pend_set", pending_any, 1);
        sw_mask[5] = 1'b0;
        tick();
        check("mask_pend_clr", pending_any, 0);
        sw_mask[5] = 1'b1;
        evt_ready = 1'b1;
        run(6);
        check("mask_n", served.size(), 1);
        check("mask_only6", served_at(0) % 16, 6);

        // Reset mid-event
        served.delete();
        evt_ready = 1'b0;
        flip(7);
        run(3);
        check("rst_pres_v", evt_valid, 1);
        check("rst_pres_idx", evt_idx, 7);
        reset = 1'b1;
        tick();
        check("rst_mid_v", evt_valid, 0);
        reset = 1'b0;
        tick();
        flip(0); flip(8);
        evt_ready = 1'b1;
        run(8);
        check("rst_n", served.size(), 2);
        check("rst_first0", served_at(0) % 16, 0);
        check("rst_then8", served_at(1) % 16, 8);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) flip(int'($urandom_range(N - 1)));
            if ($urandom_range(15) == 0) flip(int'($urandom_range(N - 1)));
            if ($urandom_range(31) == 0) begin
                int b;
                b = int'($urandom_range(N - 1));
                sw_mask[b] = ~sw_mask[b];
            end
            evt_ready   = ($urandom_range(1) == 1);
            clr_overrun = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            reset       = ($urandom_range(199) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
